// File: rtl/store_trace_pkg.sv
// rtl/store_trace_pkg.sv - shared types and defaults for the store trace buffer
package store_trace_pkg;

  localparam int DEFAULT_DEPTH  = 8;
  localparam int DEFAULT_DROP_W = 16;

  // One captured store; pc first so the packed layout reads like the trace line.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
  } trace_entry_t;

  // Address-window match used by the optional capture filter.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] mask,
                                          input logic [31:0] base);
    return (addr & mask) == base;
  endfunction

endpackage

// File: rtl/store_trace_buffer_if.sv
// rtl/store_trace_buffer_if.sv - core-store capture and trace stream bundle
interface store_trace_buffer_if import store_trace_pkg::*; #(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DROP_W = DEFAULT_DROP_W
) ();

  localparam int LW = $clog2(DEPTH) + 1;

  // Store side, driven by the core's memory-write port.
  logic              MemWrite;
  logic [31:0]       DataAdr;
  logic [31:0]       WriteData;
  logic [31:0]       PC;

  // Trace stream side.
  logic              trace_valid;
  logic              trace_ready;
  logic [31:0]       trace_addr;
  logic [31:0]       trace_data;
  logic [31:0]       trace_pc;

  // Status.
  logic [LW-1:0]     level;
  logic              overflow;
  logic [DROP_W-1:0] drop_count;

  // Environment side: the core plus the trace consumer.
  modport master (
    output MemWrite, DataAdr, WriteData, PC, trace_ready,
    input  trace_valid, trace_addr, trace_data, trace_pc,
    input  level, overflow, drop_count
  );

  // The trace buffer itself.
  modport slave (
    input  MemWrite, DataAdr, WriteData, PC, trace_ready,
    output trace_valid, trace_addr, trace_data, trace_pc,
    output level, overflow, drop_count
  );

endinterface

// File: rtl/store_trace_buffer_trace_fifo.sv
// rtl/store_trace_buffer_trace_fifo.sv - show-ahead FIFO of store trace entries
module trace_fifo import store_trace_pkg::*; #(
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  trace_entry_t push_data_i,
  input  logic         pop_i,
  output trace_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [LW-1:0] level_o
);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  trace_entry_t  mem_q [DEPTH];
  trace_entry_t  head_q, head_d;
  logic [LW-1:0] wr_cnt_q, wr_cnt_d;
  logic [LW-1:0] rd_cnt_q, rd_cnt_d;
  logic          do_push, do_pop;

  // Counters carry one extra wrap bit so their difference reaches DEPTH.
  assign level_o = wr_cnt_q - rd_cnt_q;
  assign full_o  = (level_o == FULL_LVL);
  assign empty_o = (level_o == '0);

  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  assign wr_cnt_d = wr_cnt_q + LW'(do_push);
  assign rd_cnt_d = rd_cnt_q + LW'(do_pop);

  // Next head: the incoming entry when it lands straight at the head slot,
  // otherwise the stored entry at the new read pointer; hold when going empty.
  always_comb begin
    head_d = head_q;
    if (wr_cnt_d != rd_cnt_d) begin
      if (do_push && (wr_cnt_q == rd_cnt_d)) begin
        head_d = push_data_i;
      end else begin
        head_d = mem_q[rd_cnt_d[AW-1:0]];
      end
    end
  end

  // Storage array write; contents need no reset because the counters gate use.
  always_ff @(posedge clk) begin
    if (do_push && !reset) begin
      mem_q[wr_cnt_q[AW-1:0]] <= push_data_i;
    end
  end

  // Pointers and registered head entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      head_q   <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      head_q   <= head_d;
    end
  end

  assign head_o = head_q;

endmodule

// File: rtl/store_trace_buffer.sv
// rtl/store_trace_buffer.sv - store capture, drop accounting; optional STORE_TRACE_FILTER_EN address filter
module store_trace_buffer import store_trace_pkg::*; #(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DROP_W = DEFAULT_DROP_W
`ifdef STORE_TRACE_FILTER_EN
  ,
  parameter logic [31:0] FILT_BASE = 32'h0,
  parameter logic [31:0] FILT_MASK = 32'h0
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  store_trace_buffer_if.slave  bus
);

  localparam int LW = $clog2(DEPTH) + 1;

  trace_entry_t      push_entry;
  trace_entry_t      head;
  logic              push_req;
  logic              push_ok;
  logic              pop;
  logic              full;
  logic              empty;
  logic              drop;
  logic [LW-1:0]     fifo_level;
  logic              overflow_q, overflow_d;
  logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

  assign push_entry = '{pc: bus.PC, addr: bus.DataAdr, data: bus.WriteData};

`ifdef STORE_TRACE_FILTER_EN
  assign push_req = bus.MemWrite && addr_in_window(bus.DataAdr, FILT_MASK, FILT_BASE);
`else
  assign push_req = bus.MemWrite;
`endif

  // trace_ready only feeds the pop decision; a full FIFO still accepts a
  // store when its head leaves on the same edge.
  assign pop     = !empty && bus.trace_ready;
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && full && !pop;

  trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push_ok),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (full),
    .empty_o     (empty),
    .level_o     (fifo_level)
  );

  // Sticky overflow flag and saturating drop counter.
  always_comb begin
    overflow_d = overflow_q || drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  // Drop accounting registers, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.trace_valid = !empty;
  assign bus.trace_addr  = head.addr;
  assign bus.trace_data  = head.data;
  assign bus.trace_pc    = head.pc;
  assign bus.level       = fifo_level;
  assign bus.overflow    = overflow_q;
  assign bus.drop_count  = drop_cnt_q;

endmodule

// File: tb/tb_store_trace_buffer.sv
// tb/tb_store_trace_buffer.sv - randomized and directed bench for store_trace_buffer
module tb_store_trace_buffer;
  import store_trace_pkg::*;

  localparam int DEPTH  = 8;
  localparam int DROP_W = 16;
  localparam int MAX_DROPS = (1 << DROP_W) - 1;
`ifdef STORE_TRACE_FILTER_EN
  localparam logic [31:0] A_OK = 32'h104;
`else
  localparam logic [31:0] A_OK = 32'h64;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  store_trace_buffer_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();
  store_trace_buffer_if #(.DEPTH(2), .DROP_W(2)) bus_s ();

`ifdef STORE_TRACE_FILTER_EN
  store_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W),
                       .FILT_BASE(32'h100), .FILT_MASK(32'hFFFFFF00))
    dut (.clk(clk), .reset(reset), .bus(bus));
  store_trace_buffer #(.DEPTH(2), .DROP_W(2),
                       .FILT_BASE(32'h100), .FILT_MASK(32'hFFFFFF00))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));
`else
  store_trace_buffer #(.DEPTH(DEPTH), .DROP_W(DROP_W))
    dut (.clk(clk), .reset(reset), .bus(bus));
  store_trace_buffer #(.DEPTH(2), .DROP_W(2))
    dut_s (.clk(clk), .reset(reset), .bus(bus_s));
`endif

  int n_checks = 0;
  int n_pass   = 0;

  trace_entry_t model_q[$];
  trace_entry_t last_head = '0;
  bit           m_ovf = 1'b0;
  int           m_drops = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic bit captured(input logic mw, input logic [31:0] adr);
`ifdef STORE_TRACE_FILTER_EN
    return mw && ((adr & 32'hFFFFFF00) == 32'h100);
`else
    return mw;
`endif
  endfunction

  // Advance the reference by one edge from the current inputs, clock, then compare.
  task automatic tick();
    trace_entry_t e;
    bit was_full, popped;
    e = '{pc: bus.PC, addr: bus.DataAdr, data: bus.WriteData};
    if (reset) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_drops = 0;
      last_head = '0;
    end else begin
      was_full = (model_q.size() == DEPTH);
      popped   = (model_q.size() != 0) && bus.trace_ready;
      if (popped) void'(model_q.pop_front());
      if (captured(bus.MemWrite, bus.DataAdr)) begin
        if (was_full && !popped) begin
          m_ovf = 1'b1;
          if (m_drops < MAX_DROPS) m_drops++;
        end else begin
          model_q.push_back(e);
        end
      end
      if (model_q.size() != 0) last_head = model_q[0];
    end
    @(posedge clk);
    #1;
    check("valid", bus.trace_valid, model_q.size() != 0);
    check("level", bus.level, model_q.size());
    check("overflow", bus.overflow, m_ovf);
    check("drop_count", bus.drop_count, m_drops);
    check("head_addr", bus.trace_addr, last_head.addr);
    check("head_data", bus.trace_data, last_head.data);
    check("head_pc", bus.trace_pc, last_head.pc);
  endtask

  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [31:0] pc, input logic rdy);
    bus.MemWrite = mw; bus.DataAdr = adr; bus.WriteData = dat; bus.PC = pc; bus.trace_ready = rdy;
  endtask

  task automatic do_reset();
    drive(1'b0, '0, '0, '0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, '0, '0, 1'b0);
    bus_s.MemWrite = 1'b0; bus_s.DataAdr = '0; bus_s.WriteData = '0;
    bus_s.PC = '0; bus_s.trace_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    tick();
    tick();
    check("rst_valid", bus.trace_valid, 0);
    check("rst_level", bus.level, 0);
    check("rst_addr", bus.trace_addr, 0);
    reset = 1'b0;

    // Single store
    drive(1'b1, A_OK, 32'd7, 32'h20, 1'b0);
    tick();
    check("single_valid", bus.trace_valid, 1);
    check("single_addr", bus.trace_addr, A_OK);
    check("single_data", bus.trace_data, 7);
    check("single_pc", bus.trace_pc, 32'h20);
    check("single_level", bus.level, 1);
    drive(1'b0, '0, '0, '0, 1'b1);
    tick();
    check("single_pop_level", bus.level, 0);
    check("single_pop_valid", bus.trace_valid, 0);

    // Fill and overflow
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, A_OK + 32'(4 * i), 32'(i), 32'h1000 + 32'(i), 1'b0);
      tick();
    end
    check("fill_level", bus.level, 8);
    check("fill_overflow", bus.overflow, 1);
    check("fill_drops", bus.drop_count, 2);
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      check("drain_order", bus.trace_data, i);
      tick();
    end
    check("drain_empty", bus.trace_valid, 0);

    // Full with concurrent push and pop
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, A_OK, 32'h10 + 32'(i), 32'h40, 1'b0);
      tick();
    end
    drive(1'b1, A_OK, 32'hAA, 32'h44, 1'b1);
    tick();
    check("pp_level", bus.level, 8);
    check("pp_drops", bus.drop_count, 0);
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("pp_last", bus.trace_data, 32'hAA);
      tick();
    end

    // Streaming with trace_ready held high
    do_reset();
    for (int i = 0; i < 100; i++) begin
      drive(1'b1, A_OK, 32'(i), 32'h80, 1'b1);
      tick();
      check("stream_lvl_le1", bus.level <= 1, 1);
    end
    check("stream_ovf", bus.overflow, 0);

    // Reset mid-stream with a store in the reset cycle
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, A_OK, 32'h50 + 32'(i), 32'h90, 1'b0);
      tick();
    end
    drive(1'b1, A_OK, 32'h77, 32'h94, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    tick();
    check("midrst_level", bus.level, 0);
    check("midrst_valid", bus.trace_valid, 0);
    check("midrst_drops", bus.drop_count, 0);

`ifdef STORE_TRACE_FILTER_EN
    // Address filter
    do_reset();
    drive(1'b1, 32'h104, 32'h1, 32'hA0, 1'b0);
    tick();
    drive(1'b1, 32'h64, 32'h2, 32'hA4, 1'b0);
    tick();
    check("filt_level", bus.level, 1);
    check("filt_addr", bus.trace_addr, 32'h104);
    check("filt_drops", bus.drop_count, 0);
`endif

    // Drop counter saturation on the small instance
    do_reset();
    bus_s.MemWrite = 1'b1; bus_s.DataAdr = A_OK; bus_s.WriteData = 32'h5;
    for (int i = 0; i < 6; i++) tick();
    bus_s.MemWrite = 1'b0;
    check("sat_level", bus_s.level, 2);
    check("sat_overflow", bus_s.overflow, 1);
    check("sat_drops", bus_s.drop_count, 3);

    // Randomized traffic with varying consumer pressure
    do_reset();
    for (int blk = 0; blk < 20; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 100);
      for (int i = 0; i < 100; i++) begin
        reset = ($urandom_range(0, 199) == 0);
        drive($urandom_range(0, 99) < 60,
              ($urandom_range(0, 1) != 0) ? (32'h100 | 32'($urandom_range(0, 255))) : $urandom,
              $urandom, $urandom, $urandom_range(0, 99) < rdy_pct);
        tick();
      end
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
